// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V fetch stage: PC, imem req/ack, skid buffer, redirect squash
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        drop;

    logic        ack;
    logic        consume;
    logic [31:0] redirect_target;
    logic [31:0] next_addr;

    assign ack             = imem_req & imem_ack;
    assign consume         = instr_valid & ~stall;
    assign redirect_target = redirect_pc & ~32'h3;
    assign next_addr       = req_addr + 32'd4;
    assign imem_addr       = req_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            imem_req    <= 1'b0;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= 32'd0;
            pc_out      <= 32'd0;
            skid_instr  <= 32'd0;
            skid_pc     <= 32'd0;
        end else if (redirect) begin
            pc          <= redirect_target;
            instr_valid <= 1'b0;
            instr_out   <= 32'd0;
            skid_instr  <= 32'd0;
            skid_pc     <= 32'd0;
            if (state == S_FETCH) begin
                // Without an ack the request must finish at its old address, so mark it for discard.
                if (ack) begin
                    req_addr <= redirect_target;
                    drop     <= 1'b0;
                end else begin
                    drop     <= 1'b1;
                end
            end else begin
                state    <= S_FETCH;
                imem_req <= 1'b1;
                req_addr <= redirect_target;
                drop     <= 1'b0;
            end
        end else begin
            if (consume) begin
                instr_valid <= 1'b0;
                instr_out   <= 32'd0;
            end
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    req_addr <= pc;
                end
                S_FETCH: begin
                    if (ack) begin
                        if (drop) begin
                            drop     <= 1'b0;
                            req_addr <= pc;
                        end else if (!instr_valid || !stall) begin
                            instr_out   <= imem_rdata;
                            pc_out      <= req_addr;
                            instr_valid <= 1'b1;
                            pc          <= next_addr;
                            req_addr    <= next_addr;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= req_addr;
                            pc         <= next_addr;
                            state      <= S_HOLD;
                            imem_req   <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    // The output slot is always live here, so stall=0 means it is consumed this edge.
                    if (!stall) begin
                        instr_out   <= skid_instr;
                        pc_out      <= skid_pc;
                        instr_valid <= 1'b1;
                        req_addr    <= pc;
                        state       <= S_FETCH;
                        imem_req    <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V pipeline, directly upstream of `instruction_decode`. It owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. It presents one registered instruction word per accepted fetch to decode, honours back-pressure from a `stall` input through a one-entry skid buffer, and squashes in-flight fetches on a branch/jump redirect. Squashed and empty slots are driven as `32'd0`, which decode treats as NOP.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] must be 0.
- `clock`  in  1: rising-edge clock for all state.
- `reset_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request; held high until `imem_ack`.
- `imem_addr`  out  32: word-aligned fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1: memory response; sampled only when `imem_req` is high.
- `imem_rdata`  in  32: instruction word; valid with `imem_ack`.
- `redirect`  in  1: one-cycle pulse that loads the PC from `redirect_pc` (taken branch/JAL/JALR).
- `redirect_pc`  in  32: target address; bits [1:0] are ignored and forced to 0.
- `stall`  in  1: downstream cannot accept; holds `instr_out` and `pc_out`.
- `instr_valid`  out  1: `instr_out` and `pc_out` hold a live instruction.
- `instr_out`  out  32: instruction word to decode (`data_in` of `instruction_decode`).
- `pc_out`  out  32: address of `instr_out`.

## Operation
- Registers: `pc` (next fetch address), `req_addr` (drives `imem_addr`), output slot (`instr_out`, `pc_out`, `instr_valid`), skid slot (word + PC), `drop` flag, state.
- States:
  - IDLE: one cycle after reset; `imem_req`=0.
  - FETCH: `imem_req`=1.
  - HOLD: skid slot full; `imem_req`=0.
- IDLE -> FETCH: `req_addr`<=`pc`.
- Consume rule: the output slot is consumed at an edge where `instr_valid`=1 and `stall`=0.
- FETCH, ack with `drop`=0 and the slot free or being consumed:
  - `instr_out`<=`imem_rdata`, `pc_out`<=`req_addr`, `instr_valid`<=1.
  - `pc`<=`req_addr`+4 and `req_addr`<=`req_addr`+4. Stay in FETCH, so back-to-back requests are possible.
- FETCH, ack with `drop`=0, `instr_valid`=1 and `stall`=1: write the data into the skid slot, `pc`<=`req_addr`+4, go to HOLD.
- FETCH, ack with `drop`=1: discard the data, clear `drop`, `req_addr`<=`pc`, stay in FETCH.
- Output slot consumed with no new data arriving: `instr_valid`<=0, `instr_out`<=0.
- HOLD with `stall`=0: output slot <= skid slot, `req_addr`<=`pc`, go to FETCH.
- Redirect has the highest priority at any edge where `redirect`=1:
  - `pc`<=`{redirect_pc[31:2],2'b00}`.
  - `instr_valid`<=0, `instr_out`<=0, skid slot cleared.
  - In FETCH with no ack this edge: set `drop`=1. `req_addr` is left unchanged, so the outstanding request completes and is then discarded.
  - In FETCH with ack this edge: discard the data, `req_addr`<=new PC.
  - In HOLD or IDLE: go to FETCH with `req_addr`<=new PC.
- Redirect during `stall` still squashes. `stall` never blocks a redirect.
- PC arithmetic: 32-bit modulo, so `32'hFFFF_FFFC`+4 = `32'h0000_0000`.

## Timing
- Reset, asynchronous:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_out`=0, `pc_out`=0.
  - `pc`=`RESET_PC`, `drop`=0, state IDLE.
- After `reset_n` rises: first edge goes IDLE->FETCH; `imem_req` is high in the second cycle.
- Ack sampled at edge N gives `instr_valid`/`instr_out` updated after edge N (visible in cycle N+1).
- A zero-wait memory (ack in every FETCH cycle) sustains 1 instruction/cycle.
- At most one request is outstanding at any time. `imem_addr` never changes while `imem_req`=1 and `imem_ack`=0.
- Redirect at edge N: `instr_valid`=0 in cycle N+1. The first redirected word appears one edge after its ack, plus one extra ack if a request was in flight.
- Reset mid-request: the request is abandoned immediately. Memory must ignore a dropped `imem_req`.

## Test plan
- Reset release with zero-wait memory returning `addr^32'hA5A5_0000`, `RESET_PC`=0 -> `imem_req` high in cycle 2; `pc_out` runs 0,4,8,... on consecutive cycles with `instr_valid`=1.
- Memory with 3-cycle ack latency -> `imem_addr` stable for 3 cycles per request; `instr_valid` pulses once per 3 cycles; `pc_out` increments by 4 each time.
- Assert `stall` for 5 cycles while a fetch is in flight -> `instr_out`/`pc_out` frozen; skid captures the next word; state HOLD with `imem_req`=0; after `stall` drops, both words are delivered in order with no gap or loss.
- `redirect` with `redirect_pc`=`32'h100` while a 3-cycle fetch at `32'h40` is outstanding -> `instr_valid`=0 and `instr_out`=0 next cycle; the `32'h40` data is never presented; the next request is `imem_addr`=`32'h100`.
- `redirect_pc`=`32'h0000_0203` and PC at `32'hFFFF_FFFC` -> fetch from `32'h200`; a separate run shows a wrap from `32'hFFFF_FFFC` to `32'h0`.
- Assert `reset_n`=0 mid-request and while in HOLD -> all outputs at reset values asynchronously; a clean restart from `RESET_PC`.
